// File: rtl/sys_run_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sys_run_monitor
// Purpose  : Core reset sequencer, end-of-run detector and out_byte FIFO.
// Revision : 1.0
// ============================================================================
module sys_run_monitor #(
    parameter int RESET_CYCLES   = 100,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int FIFO_DEPTH     = 16,
    parameter int DATA_W         = 8
) (
    input  logic              clk,
    input  logic              resetn,
    output logic              core_resetn,
    input  logic              trap,
    input  logic [DATA_W-1:0] out_byte,
    input  logic              out_byte_en,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic [1:0]        status,
    output logic              overflow,
    output logic [15:0]       byte_count,
    output logic [31:0]       cycle_count
);

    localparam int              c_aw           = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              c_hw           = $clog2(RESET_CYCLES + 1);
    localparam logic [c_aw:0]   c_depth        = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [c_hw-1:0] c_hold_last    = c_hw'(RESET_CYCLES - 1);
    localparam logic [31:0]     c_timeout_last = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD         = 2'd0,
        S_RUN          = 2'd1,
        S_TRAP_DONE    = 2'd2,
        S_TIMEOUT_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [c_hw-1:0]   hold_cnt_q, hold_cnt_d;
    logic [31:0]       cycle_cnt_q, cycle_cnt_d;
    logic              core_resetn_q;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_aw:0]     occ_q, occ_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;

    logic              w_push_req;
    logic              w_pop;
    logic              w_full;
    logic              w_push;

    // ------------------------------------------------------------------
    // Run sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == c_hold_last) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + c_hw'(1);
                end
            end
            S_RUN: begin
                if (cycle_cnt_q != 32'hFFFF_FFFF) begin
                    cycle_cnt_d = cycle_cnt_q + 32'd1;
                end
                // Trap has priority over a coincident timeout.
                if (trap) begin
                    state_d = S_TRAP_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cycle_cnt_q == c_timeout_last)) begin
                    state_d = S_TIMEOUT_DONE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= '0;
            cycle_cnt_q   <= '0;
            core_resetn_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cycle_cnt_q   <= cycle_cnt_d;
            core_resetn_q <= (state_d != S_HOLD);
        end
    end

    // ------------------------------------------------------------------
    // out_byte FIFO (first-word fall-through, no write-to-read bypass)
    // ------------------------------------------------------------------
    assign w_push_req = (state_q == S_RUN) && out_byte_en;
    assign w_pop      = (occ_q != '0) && rd_ready;
    assign w_full     = (occ_q == c_depth);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        overflow_d = overflow_q;
        byte_cnt_d = byte_cnt_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_aw'(1);
            if (byte_cnt_q != 16'hFFFF) begin
                byte_cnt_d = byte_cnt_q + 16'd1;
            end
        end
        if (w_push_req && !w_push) begin
            overflow_d = 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_aw'(1);
        end
        case ({w_push, w_pop})
            2'b10:   occ_d = occ_q + (c_aw + 1)'(1);
            2'b01:   occ_d = occ_q - (c_aw + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= out_byte;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign core_resetn = core_resetn_q;
    assign rd_valid    = (occ_q != '0);
    assign rd_data     = mem_q[rd_ptr_q];
    assign done        = (state_q == S_TRAP_DONE) || (state_q == S_TIMEOUT_DONE);
    assign status      = (state_q == S_TRAP_DONE)    ? 2'd1 :
                         (state_q == S_TIMEOUT_DONE) ? 2'd2 : 2'd0;
    assign overflow    = overflow_q;
    assign byte_count  = byte_cnt_q;
    assign cycle_count = cycle_cnt_q;

endmodule
`default_nettype wire

// File: doc/sys_run_monitor.md
Name: sys_run_monitor

Overview:
Parametrised run controller and monitor for the picorv32 system wrapper.
- Sequences core reset release after a programmable hold.
- Detects end of run: trap, or optional cycle timeout.
- Buffers the core's out_byte stream in a FIFO drained over a valid/ready port.
- Sits between board/bench reset and the system instance; works in synthesis and simulation.

Parameters:
RESET_CYCLES, 100, cycles core_resetn is held low after resetn deasserts (>=1)
TIMEOUT_CYCLES, 0, run cycles before forced timeout; 0 disables timeout
FIFO_DEPTH, 16, out_byte buffer entries (power of two, >=2)
DATA_W, 8, width of out_byte / FIFO entries

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
core_resetn  out  1  registered reset to the core, active-low
trap  in  1  core trap flag
out_byte  in  DATA_W  core output byte
out_byte_en  in  1  out_byte strobe, one byte per cycle high
rd_ready  in  1  consumer pops the FIFO head
rd_valid  out  1  FIFO non-empty
rd_data  out  DATA_W  FIFO head (first-word fall-through)
done  out  1  run finished (sticky)
status  out  2  0 running/hold, 1 trap, 2 timeout
overflow  out  1  sticky: a byte was dropped on a full FIFO
byte_count  out  16  accepted bytes, saturating at 16'hFFFF
cycle_count  out  32  cycles spent in RUN, saturating

Behaviour:
- Reset is resetn, synchronous, active-low; clock is clk. All state is registered on the rising edge of clk.
- While resetn=0:
  - state=HOLD, hold counter=0.
  - core_resetn=0, done=0, status=0, overflow=0.
  - byte_count=0, cycle_count=0.
  - FIFO pointers cleared: rd_valid=0, rd_data don't-care.
- Asserting resetn=0 mid-run aborts immediately and discards FIFO contents.
- FSM states:
  - HOLD -> RUN when hold counter reaches RESET_CYCLES-1. core_resetn goes 1 on the RESET_CYCLES-th rising edge with resetn=1.
  - RUN -> TRAP_DONE when trap=1 is sampled in RUN. At the next edge: done=1, status=1.
  - RUN -> TIMEOUT_DONE when TIMEOUT_CYCLES!=0, cycle_count==TIMEOUT_CYCLES-1, and trap=0. At the next edge: done=1, status=2.
  - Trap and timeout in the same cycle: trap wins (status=1).
  - TRAP_DONE and TIMEOUT_DONE are absorbing until resetn=0.
  - core_resetn stays 1 in both done states so the core state stays inspectable.
- trap is ignored in HOLD (the core is in reset).
- cycle_count:
  - Increments each RUN cycle, including the cycle trap is sampled.
  - Frozen in the done states.
  - Saturates at 32'hFFFFFFFF.
- Byte capture:
  - A byte is written when state==RUN and out_byte_en=1.
  - The capture cycle where trap is sampled still writes.
  - Bytes are ignored in HOLD and in the done states.
- FIFO write rules:
  - Not full: write accepted and byte_count increments.
  - Full and rd_ready=0: byte dropped, overflow<=1, byte_count unchanged.
  - Full with rd_valid & rd_ready in the same cycle: pop and push both happen, write accepted, occupancy unchanged.
  - Empty with simultaneous push: rd_valid rises the following cycle (no same-cycle bypass).
- FIFO read rules:
  - Pop occurs when rd_valid & rd_ready.
  - rd_ready with an empty FIFO is ignored; no underflow.
  - rd_data is valid whenever rd_valid=1 and is stable while rd_ready=0.
  - Pointers wrap modulo FIFO_DEPTH. A separate occupancy count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
- The FIFO stays drainable in the done states; done does not depend on FIFO occupancy.
- Latencies:
  - out_byte_en to rd_valid: 1 cycle.
  - trap to done: 1 cycle.
  - resetn high to core_resetn high: RESET_CYCLES cycles.

Test Plan:
- RESET_CYCLES=100, resetn released at cycle 0 -> core_resetn=0 through edge 99, =1 after edge 100; done=0, status=0, cycle_count=0 until RUN.
- In RUN, push 0x48,0x69,0x0A one per cycle with rd_ready=0 -> rd_valid=1, rd_data=0x48; pop three times -> 0x48,0x69,0x0A in order, then rd_valid=0; byte_count=3.
- FIFO_DEPTH=16, push 18 bytes with rd_ready=0 -> first 16 kept, overflow=1, byte_count=16; then push with rd_ready=1 while full -> accepted, byte_count=17, occupancy stays 16.
- trap asserted 50 cycles into RUN together with out_byte_en, byte 0x21 -> next edge done=1, status=1, cycle_count=51, 0x21 stored; later bytes and trap toggles ignored.
- TIMEOUT_CYCLES=200, trap held low -> done=1, status=2 one edge after cycle_count==199; same test with trap=1 in that exact cycle -> status=1.
- resetn pulsed low for 1 cycle mid-run with 5 bytes buffered -> done=0, status=0, overflow=0, rd_valid=0, core_resetn=0, and a fresh RESET_CYCLES hold is restarted.
